// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 3-to-8 decoder with enable.
// Define DEC_ARB_GAP_EN to insert a one-cycle en=0 break between leases.
module dec_rr_arbiter #(
    parameter int GRANT_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       en,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy
);

`ifdef DEC_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [7:0]         grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [7:0]         rot_req;
    logic [2:0]         win_off;
    logic [2:0]         winner;
    logic               lease_end;
    logic               start_grant;

    // rot_req[k] is the request that sits k+1 places after the last grant
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[3'(last_q + 3'(gi + 1))];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) win_off = 3'(k);
        end
    end

    assign winner    = last_q + win_off + 3'd1;
    assign lease_end = (cnt_q == CNT_W'(GRANT_CYCLES - 1)) || done || !req[sel_q];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        start_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) start_grant = 1'b1;
            end
            GRANT: begin
                if (lease_end) begin
`ifdef DEC_ARB_GAP_EN
                    state_d = GAP;
`else
                    if (|req) start_grant = 1'b1;
                    else      state_d     = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef DEC_ARB_GAP_EN
            GAP: begin
                if (|req) start_grant = 1'b1;
                else      state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (start_grant) begin
            state_d = GRANT;
            sel_d   = winner;
            last_d  = winner;
            cnt_d   = '0;
        end
        // outputs are decoded from the next state so they leave flops directly
        en_d    = (state_d == GRANT);
        grant_d = en_d ? (8'd1 << sel_d) : 8'h00;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            last_q  <= 3'd7;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            grant_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign en    = en_q;
    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
